// File: rtl/apb_gpio_out_slave_if.sv
// APB3 completer-side bus bundle for apb_gpio_out_slave.
// Clock and reset are not part of this bundle; they stay plain ports on the slave.
interface apb_gpio_out_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_out_slave.sv
// APB3 GPIO output slave: DATA register with set/clear/toggle aliases, an ID register,
// and a programmable wait-state count on PREADY. Illegal accesses return PSLVERR.
module apb_gpio_out_slave #(
  parameter int unsigned                  GPIO_WIDTH = 32,
  parameter logic [GPIO_WIDTH-1:0]        GPIO_RESET = '0,
  parameter logic [3:0]                   WAIT_RESET = 4'd0,
  parameter logic [31:0]                  BLOCK_ID   = 32'h4750_4F31
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  apb_gpio_out_slave_if.slave   apb,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  localparam logic [5:0] OFF_DATA = 6'h00;
  localparam logic [5:0] OFF_SET  = 6'h01;
  localparam logic [5:0] OFF_CLR  = 6'h02;
  localparam logic [5:0] OFF_TGL  = 6'h03;
  localparam logic [5:0] OFF_WCFG = 6'h04;
  localparam logic [5:0] OFF_ID   = 6'h05;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [3:0]            waitcfg;
  logic [GPIO_WIDTH-1:0] data;

  logic [31:0] data_ext;
  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic        err;
  logic        we_data;
  logic        we_wcfg;
  logic        access;
  logic        unused_bits;

  // Decode runs in the 32-bit bus domain; DATA bits at or above GPIO_WIDTH drop on commit.
  always_comb begin
    data_ext                   = '0;
    data_ext[GPIO_WIDTH-1:0]   = data;
    rd_val                     = '0;
    wr_val                     = data_ext;
    err                        = 1'b0;
    we_data                    = 1'b0;
    we_wcfg                    = 1'b0;
    case (apb.PADDR[7:2])
      OFF_DATA: begin
        rd_val  = data_ext;
        wr_val  = apb.PWDATA;
        we_data = 1'b1;
      end
      OFF_SET: begin
        wr_val  = data_ext | apb.PWDATA;
        we_data = 1'b1;
      end
      OFF_CLR: begin
        wr_val  = data_ext & ~apb.PWDATA;
        we_data = 1'b1;
      end
      OFF_TGL: begin
        wr_val  = data_ext ^ apb.PWDATA;
        we_data = 1'b1;
      end
      OFF_WCFG: begin
        rd_val  = {28'd0, waitcfg};
        we_wcfg = 1'b1;
      end
      OFF_ID: begin
        rd_val  = BLOCK_ID;
        err     = apb.PWRITE;
      end
      default: err = 1'b1;
    endcase
  end

  assign access      = (state == ST_LAST) && apb.PSEL && apb.PENABLE;
  assign apb.PREADY  = access;
  assign apb.PSLVERR = access && err;
  assign apb.PRDATA  = (access && !err && !apb.PWRITE) ? rd_val : '0;

  assign unused_bits = ^{apb.PADDR[31:8], apb.PADDR[1:0], wr_val};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      waitcfg  <= WAIT_RESET;
      data     <= GPIO_RESET;
      GPIO_OUT <= GPIO_RESET;
    end else begin
      GPIO_OUT <= data;
      case (state)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            cnt   <= waitcfg;
            state <= (waitcfg != 4'd0) ? ST_WAIT : ST_LAST;
          end
        end
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state <= ST_IDLE;
          end else if (apb.PENABLE) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= ST_LAST;
            end
          end
        end
        ST_LAST: begin
          state <= ST_IDLE;
          if (access && apb.PWRITE && !err) begin
            if (we_data) begin
              data <= wr_val[GPIO_WIDTH-1:0];
            end
            if (we_wcfg) begin
              waitcfg <= apb.PWDATA[3:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
